// File: rtl/udp_arb_pkg.sv
// Shared types and constants for the UDP command arbiter.
// Payload byte layout: requester ID in the top bits, command below it.
package udp_arb_pkg;

    localparam int NUM_REQ    = 4;
    localparam int CMD_W      = 6;
    localparam int ID_W       = 2;
    localparam int PL_W       = ID_W + CMD_W;
    localparam int PL_CMD_LSB = 0;
    localparam int PL_ID_LSB  = CMD_W;

    localparam logic [15:0] UDP_LEN = 16'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_SEND,
        ST_WAIT_RDY,
        ST_DONE
    } state_e;

    function automatic logic [PL_W-1:0] make_payload(input logic [ID_W-1:0]  id,
                                                     input logic [CMD_W-1:0] cmd);
        logic [PL_W-1:0] p;
        p = '0;
        p[PL_ID_LSB  +: ID_W]  = id;
        p[PL_CMD_LSB +: CMD_W] = cmd;
        return p;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set pending bit after last_grant, wrapping.
module rr_arbiter
    import udp_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] pending,
    input  logic [ID_W-1:0]    last_grant,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant
);

    logic [ID_W-1:0] idx;

    always_comb begin
        grant_valid = 1'b0;
        grant       = last_grant;
        idx         = last_grant;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = last_grant + ID_W'(k);
            if (!grant_valid && pending[idx]) begin
                grant_valid = 1'b1;
                grant       = idx;
            end
        end
    end

endmodule

// File: rtl/udp_cmd_arbiter.sv
// Arbitrates four 6-bit command requesters onto a one-byte UDP payload channel,
// with a per-transfer timeout that drops the command and reports tx_err.
module udp_cmd_arbiter #(
    parameter int unsigned ACK_TIMEOUT = 50000,
    parameter int          NUM_REQ     = 4
) (
    input  logic                                  clk_50,
    input  logic                                  sys_rst_n,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ*udp_arb_pkg::CMD_W-1:0] req_cmd,
    output logic [NUM_REQ-1:0]                    req_ack,
    output logic [NUM_REQ-1:0]                    tx_done,
    output logic [NUM_REQ-1:0]                    tx_err,
    input  logic                                  udp_tx_ready,
    input  logic                                  app_tx_ack,
    output logic                                  app_tx_data_request,
    output logic                                  app_tx_data_valid,
    output logic [7:0]                            app_tx_data,
    output logic [15:0]                           udp_data_length
);

    import udp_arb_pkg::*;

    localparam int              CNT_W    = $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_e                          state_q, state_d;
    logic [NUM_REQ-1:0]              pending_q, pending_d;
    logic [NUM_REQ-1:0][CMD_W-1:0]   cmd_q, cmd_d;
    logic [ID_W-1:0]                 last_grant_q, last_grant_d;
    logic [ID_W-1:0]                 grant_q, grant_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [NUM_REQ-1:0]              req_ack_q, req_ack_d;
    logic [NUM_REQ-1:0]              tx_done_q, tx_done_d;
    logic [NUM_REQ-1:0]              tx_err_q, tx_err_d;
    logic                            request_q, request_d;
    logic                            valid_q, valid_d;
    logic [PL_W-1:0]                 data_q, data_d;
    logic [NUM_REQ-1:0]              clr;
    logic                            arb_valid;
    logic [ID_W-1:0]                 arb_grant;
    logic                            active;

    rr_arbiter u_rr (
        .pending    (pending_q),
        .last_grant (last_grant_q),
        .grant_valid(arb_valid),
        .grant      (arb_grant)
    );

    assign active = (state_q == ST_REQUEST) || (state_q == ST_SEND) || (state_q == ST_WAIT_RDY);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        request_d    = request_q;
        valid_d      = valid_q;
        data_d       = data_q;
        cmd_d        = cmd_q;
        req_ack_d    = '0;
        tx_done_d    = '0;
        tx_err_d     = '0;
        clr          = '0;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_grant;
                    cnt_d   = '0;
                    state_d = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                cnt_d = cnt_q + 1'b1;
                if (udp_tx_ready) begin
                    request_d = 1'b1;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                cnt_d = cnt_q + 1'b1;
                if (app_tx_ack) begin
                    request_d = 1'b0;
                    valid_d   = 1'b1;
                    data_d    = make_payload(grant_q, cmd_q[grant_q]);
                    state_d   = ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                cnt_d   = cnt_q + 1'b1;
                valid_d = 1'b0;
                if (udp_tx_ready) begin
                    tx_done_d[grant_q] = 1'b1;
                    state_d            = ST_DONE;
                end
            end
            ST_DONE: begin
                clr[grant_q] = 1'b1;
                last_grant_d = grant_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Timeout overrides whatever the active state decided this cycle.
        if (active && cnt_q == CNT_LAST) begin
            tx_done_d         = '0;
            tx_err_d[grant_q] = 1'b1;
            clr[grant_q]      = 1'b1;
            last_grant_d      = grant_q;
            request_d         = 1'b0;
            valid_d           = 1'b0;
            cnt_d             = '0;
            state_d           = ST_IDLE;
        end

        // A pending slot ignores req_valid, so a clear always wins over a same-cycle request.
        pending_d = pending_q & ~clr;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !pending_q[i]) begin
                pending_d[i] = 1'b1;
                cmd_d[i]     = req_cmd[i*CMD_W +: CMD_W];
                req_ack_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            cmd_q        <= '0;
            last_grant_q <= '1;
            grant_q      <= '0;
            cnt_q        <= '0;
            req_ack_q    <= '0;
            tx_done_q    <= '0;
            tx_err_q     <= '0;
            request_q    <= 1'b0;
            valid_q      <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            cmd_q        <= cmd_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            req_ack_q    <= req_ack_d;
            tx_done_q    <= tx_done_d;
            tx_err_q     <= tx_err_d;
            request_q    <= request_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
        end
    end

    assign req_ack             = req_ack_q;
    assign tx_done             = tx_done_q;
    assign tx_err              = tx_err_q;
    assign app_tx_data_request = request_q;
    assign app_tx_data_valid   = valid_q;
    assign app_tx_data         = data_q;
    assign udp_data_length     = UDP_LEN;

endmodule
